// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: recovers pixel coordinates, lock state and a per-frame rgb checksum from a VGA sync stream.
// Latency: every output reflects the input sample one clock earlier.
// Backpressure: none; passive observer on the pixel clock, every sample is consumed.
module vga_sync_monitor #(
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hSync,
    input  logic        vSync,
    input  logic [11:0] rgb,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        pixel_valid,
    output logic        locked,
    output logic        frame_done,
    output logic [31:0] frame_sum,
    output logic [7:0]  err_count
);
    localparam logic [9:0]  LP_H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [6:0]  LP_H_SYNC  = 7'(H_SYNC);
    localparam logic [9:0]  LP_H_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0]  LP_H_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [3:0]  LP_V_SYNC  = 4'(V_SYNC);
    localparam logic [10:0] LP_V_TOTAL = 11'(V_TOTAL);
    localparam logic [9:0]  LP_V_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  LP_V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);

    typedef enum logic [1:0] {S_UNLOCKED, S_ACQUIRE, S_LOCKED} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_hs_q;
    logic        r_vs_q;
    logic [9:0]  r_hpos;
    logic [9:0]  r_vpos;
    logic [6:0]  r_hsw;
    logic [3:0]  r_vsw;
    logic        r_err_acc;
    logic        r_skip;
    logic [31:0] r_acc;

    logic        w_hfall;
    logic        w_vfall;
    logic [9:0]  w_hpos;
    logic [9:0]  w_vpos;
    logic [6:0]  w_hsw;
    logic [3:0]  w_vsw;
    logic [10:0] w_lines;
    logic        w_line_err;
    logic        w_frame_err;
    logic        w_err_acc_nxt;
    logic        w_skip_nxt;
    logic        w_sum_load;
    logic        w_err_inc;
    logic        w_active;
    logic        w_valid;
    logic [31:0] w_acc_sum;

    assign w_hfall = r_hs_q && !hSync;
    assign w_vfall = r_vs_q && !vSync;

    // Position of the current sample; hpos restarts on the hSync fall, vpos on the vSync fall.
    assign w_hpos = w_hfall ? 10'd0 :
                    (r_hpos == 10'h3FF) ? r_hpos : r_hpos + 10'd1;
    assign w_vpos = w_vfall ? 10'd0 :
                    (w_hfall && r_vpos != 10'h3FF) ? r_vpos + 10'd1 : r_vpos;

    // Pulse widths keep counting while low and then hold until the next fall checks them.
    assign w_hsw = w_hfall ? 7'd1 :
                   (!hSync && r_hsw != 7'h7F) ? r_hsw + 7'd1 : r_hsw;
    assign w_vsw = w_vfall ? 4'd1 :
                   (!vSync && w_hfall && r_vsw != 4'hF) ? r_vsw + 4'd1 : r_vsw;

    // Lines since the last vSync fall; a coincident hSync fall closes the final line.
    assign w_lines = {1'b0, r_vpos} + {10'd0, w_hfall};

    // The first line after acquisition starts is skipped because hpos may not be aligned yet.
    assign w_line_err  = w_hfall && !r_skip &&
                         ((r_hpos != LP_H_LAST) || (r_hsw != LP_H_SYNC));
    assign w_frame_err = w_vfall && ((w_lines != LP_V_TOTAL) || (r_vsw != LP_V_SYNC));

    assign w_active  = (w_hpos >= LP_H_START) && (w_hpos < LP_H_END) &&
                       (w_vpos >= LP_V_START) && (w_vpos < LP_V_END);
    // Qualify with the next state so pixel_valid never asserts while the locked output is low.
    assign w_valid   = w_active && (w_state_nxt == S_LOCKED);
    assign w_acc_sum = r_acc + (w_valid ? {20'd0, rgb} : 32'd0);

    assign locked = (r_state == S_LOCKED);

    // Lock FSM: next state, error accumulation and checksum/error-count strobes
    always_comb begin
        w_state_nxt   = r_state;
        w_err_acc_nxt = r_err_acc;
        w_skip_nxt    = r_skip;
        w_sum_load    = 1'b0;
        w_err_inc     = 1'b0;
        case (r_state)
            S_UNLOCKED: begin
                if (w_vfall) begin
                    w_state_nxt   = S_ACQUIRE;
                    w_err_acc_nxt = 1'b0;
                    w_skip_nxt    = 1'b1;
                end
            end
            S_ACQUIRE: begin
                if (w_hfall) begin
                    w_skip_nxt = 1'b0;
                end
                if (w_vfall) begin
                    w_err_acc_nxt = 1'b0;
                    if (!r_err_acc && !w_line_err && !w_frame_err) begin
                        w_state_nxt = S_LOCKED;
                    end
                end else if (w_line_err) begin
                    w_err_acc_nxt = 1'b1;
                end
            end
            S_LOCKED: begin
                if (w_line_err || w_frame_err) begin
                    w_state_nxt = S_UNLOCKED;
                    w_err_inc   = 1'b1;
                end else if (w_vfall) begin
                    w_sum_load = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_UNLOCKED;
            end
        endcase
    end

    // Lock FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_UNLOCKED;
            r_err_acc <= 1'b0;
            r_skip    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_err_acc <= w_err_acc_nxt;
            r_skip    <= w_skip_nxt;
        end
    end

    // Sync history, position/width counters and the running checksum
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hs_q <= 1'b1;
            r_vs_q <= 1'b1;
            r_hpos <= '0;
            r_vpos <= '0;
            r_hsw  <= '0;
            r_vsw  <= '0;
            r_acc  <= '0;
        end else begin
            r_hs_q <= hSync;
            r_vs_q <= vSync;
            r_hpos <= w_hpos;
            r_vpos <= w_vpos;
            r_hsw  <= w_hsw;
            r_vsw  <= w_vsw;
            r_acc  <= w_vfall ? 32'd0 : w_acc_sum;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            frame_sum   <= '0;
            err_count   <= '0;
        end else begin
            pixel_x     <= w_valid ? w_hpos - LP_H_START : 10'd0;
            pixel_y     <= w_valid ? w_vpos - LP_V_START : 10'd0;
            pixel_valid <= w_valid;
            frame_done  <= w_sum_load;
            if (w_sum_load) begin
                frame_sum <= w_acc_sum;
            end
            if (w_err_inc && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA timing generator.
- Watches the hSync/vSync/rgb stream driven to the connector and recovers pixel coordinates and lock status from the sync pulses alone.
- Accumulates a per-frame pixel checksum so benches and on-board self-test can check the rendered maze without a monitor.
- Sits beside the top level on the 25 MHz pixel clock and taps the same nets that drive the VGA pins.

Parameters:
- H_SYNC, 96, hSync low width in clocks
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 800, clocks per line
- V_SYNC, 2, vSync low width in lines
- V_BP, 33, vertical back porch in lines
- V_ACTIVE, 480, visible lines
- V_TOTAL, 525, lines per frame

Ports:
- clk  in  1  pixel clock (25 MHz)
- reset  in  1  synchronous, active-high
- hSync  in  1  horizontal sync, active-low
- vSync  in  1  vertical sync, active-low
- rgb  in  12  pixel colour {R,G,B}
- pixel_x  out  10  recovered column, 0..639 when pixel_valid
- pixel_y  out  10  recovered row, 0..479 when pixel_valid
- pixel_valid  out  1  locked and inside active region
- locked  out  1  timing matched for a complete frame
- frame_done  out  1  one-cycle pulse, frame_sum updated
- frame_sum  out  32  sum of rgb over the last locked frame's active pixels, modulo 2^32
- err_count  out  8  lock losses, saturating at 255

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous, active-high.
- Reset values: all outputs 0. Internal hpos/vpos/sum 0. FSM in UNLOCKED. Previous-sample sync registers set to 1.
- Edge detection: sync inputs are registered once (hs_q, vs_q). A falling edge is `hs_q==1 && hSync==0` (same for vSync).
- hpos (10b, saturates at 1023):
  - 0 in the edge cycle; +1 every other cycle.
  - Equals the generator's hCount for the same sample.
- hsw (7b, saturating): counts consecutive low hSync samples since the fall.
- vpos (10b, saturates at 1023):
  - 0 on a vSync falling edge, which has priority when it coincides with an hSync edge.
  - Otherwise +1 on each hSync falling edge.
- Line check: at each hSync falling edge, except the first after leaving UNLOCKED:
  - line error if the previous hpos+1 != H_TOTAL;
  - line error if the captured hSync low width != H_SYNC.
- Frame check: at a vSync falling edge, frame error if the line count since the previous vSync fall != V_TOTAL, or the vSync low width in lines != V_SYNC.
- FSM:
  - UNLOCKED: on a vSync falling edge go to ACQUIRE and clear the error accumulator.
  - ACQUIRE:
    - on a vSync fall with no line or frame error since entry, go to LOCKED;
    - on a vSync fall with any error, stay in ACQUIRE and clear the accumulator.
  - LOCKED:
    - any line or frame error goes to UNLOCKED and increments err_count (saturating);
    - locked deasserts the cycle after the error is detected.
- Active region: hpos in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and vpos in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
- Outputs: registered, with 1 cycle latency from the input sample.
  - pixel_x = hpos-(H_SYNC+H_BP).
  - pixel_y = vpos-(V_SYNC+V_BP).
  - pixel_valid = active && locked.
  - pixel_x/pixel_y hold 0 when not valid.
- Checksum:
  - The accumulator adds zero-extended rgb on every valid pixel.
  - On a vSync fall in LOCKED with no error that cycle: frame_sum <= accumulator (including any same-cycle add), frame_done pulses 1 cycle, accumulator clears.
  - In ACQUIRE, the accumulator clears at each vSync fall; frame_done does not pulse.
  - The first frame_done follows the first full frame counted after lock.
- Reset mid-frame: returns immediately to the reset state. Relock needs two further vSync falls.
- No X propagation: all counters are defined from reset.

Test Plan:
- Nominal lock: generator at 800x525 with the stated porches, reset released mid-line.
  - locked rises 1 cycle after the second observed vSync fall.
  - err_count = 0.
- Coordinates: sample with hCount=144, vCount=35.
  - Next cycle: pixel_x=0, pixel_y=0, pixel_valid=1.
  - hCount=783, vCount=514 gives 639/479.
  - hCount=784 gives pixel_valid=0.
- Checksum: rgb fixed at 12'hFFF for a whole locked frame.
  - frame_done pulse with frame_sum = 640*480*4095 = 32'h4AFB5000.
  - rgb = 0 gives frame_sum = 0.
- Line error: shorten one line in a locked frame to 799 clocks.
  - locked drops, err_count = 1, no frame_done at that frame's vSync.
  - Relock after two clean vSync falls.
- Sync width error: hSync low for 95 clocks once gives the same response as the line error. vSync low for 3 lines does the same at the next vSync fall.
- Reset mid-frame in LOCKED: all outputs 0 on the next cycle; relock and frame_sum behave as in the nominal lock scenario.
